jtcop_pal_sched: RTL and testbench

- Scheduler for the palette RAM that feeds the colour mixer.
- Copies a CPU-written shadow palette into the live video palette during vertical blank.
- Shares the live palette write port between that bulk copy and single CPU direct writes, giving each write a byte-lane mask that matches the green/red and blue RAM split.
- Sits between the CPU bus decoder and the palette RAMs that the colour mixer reads.

---
 rtl/jtcop_pal_sched.sv | 190 +++++++++++++++++++
 tb/tb_jtcop_pal_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_pal_sched.sv
// Palette copy scheduler: streams the shadow palette into the live palette during vblank,
// interleaving single CPU writes on the live write port with byte-lane masks.
module jtcop_pal_sched #(
  parameter int AW = 10,
  parameter int DW = 24
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          LVBL,
  input  logic          trig,
  input  logic          auto_en,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic [AW-1:0] sh_addr,
  input  logic [DW-1:0] sh_dout,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_data,
  input  logic [2:0]    cpu_mask,
  output logic          cpu_ack,
  output logic [AW-1:0] live_addr,
  output logic [DW-1:0] live_data,
  output logic [2:0]    live_we
);

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  localparam logic [AW-1:0] LAST = '1;

  state_t        state_q, state_d;
  logic          lvbl_q, lvbl_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          issued_all_q, issued_all_d;
  logic          rd_vld_q, rd_vld_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          hold_vld_q, hold_vld_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic [AW-1:0] live_addr_q, live_addr_d;
  logic [DW-1:0] live_data_q, live_data_d;
  logic [2:0]    live_we_q, live_we_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          last_wr_q, last_wr_d;

  logic blank_st, blank_end, cpu_win, start, issue;

  always_comb begin
    blank_st  = lvbl_q & ~LVBL;
    blank_end = ~lvbl_q & LVBL;
    cpu_win   = cpu_req & ~cpu_ack_q;
    start     = (state_q == IDLE) & blank_st & (pending_q | auto_en);
    issue     = (state_q == COPY) & ~cpu_win & ~issued_all_q;
  end

  always_comb begin
    state_d      = state_q;
    lvbl_d       = LVBL;
    pending_d    = trig | (pending_q & ~start);
    overrun_d    = overrun_q;
    cnt_d        = cnt_q;
    issued_all_d = issued_all_q;
    rd_vld_d     = 1'b0;
    rd_addr_d    = rd_addr_q;
    hold_vld_d   = hold_vld_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    live_addr_d  = live_addr_q;
    live_data_d  = live_data_q;
    live_we_d    = 3'b000;
    cpu_ack_d    = 1'b0;
    last_wr_d    = 1'b0;

    if (start) begin
      overrun_d = 1'b0;
    end else if (blank_end && state_q == COPY) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // The counter rests at 0 in IDLE, so address 0 is already being read
        // during the start cycle.
        if (start) begin
          state_d      = COPY;
          cnt_d        = AW'(1);
          issued_all_d = 1'b0;
          rd_vld_d     = 1'b1;
          rd_addr_d    = '0;
        end
      end
      COPY: begin
        if (issue) begin
          rd_vld_d  = 1'b1;
          rd_addr_d = cnt_q;
          if (cnt_q == LAST) begin
            issued_all_d = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        if (last_wr_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Write port arbitration: CPU first, then parked copy data, then fresh read data.
    if (cpu_win) begin
      live_addr_d = cpu_addr;
      live_data_d = cpu_data;
      live_we_d   = cpu_mask;
      cpu_ack_d   = 1'b1;
      if (rd_vld_q) begin
        hold_vld_d  = 1'b1;
        hold_addr_d = rd_addr_q;
        hold_data_d = sh_dout;
      end
    end else if (hold_vld_q) begin
      live_addr_d = hold_addr_q;
      live_data_d = hold_data_q;
      live_we_d   = 3'b111;
      hold_vld_d  = 1'b0;
      last_wr_d   = (hold_addr_q == LAST);
    end else if (rd_vld_q) begin
      live_addr_d = rd_addr_q;
      live_data_d = sh_dout;
      live_we_d   = 3'b111;
      last_wr_d   = (rd_addr_q == LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lvbl_q       <= 1'b1;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      cnt_q        <= '0;
      issued_all_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_addr_q    <= '0;
      hold_vld_q   <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      live_addr_q  <= '0;
      live_data_q  <= '0;
      live_we_q    <= 3'b000;
      cpu_ack_q    <= 1'b0;
      last_wr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lvbl_q       <= lvbl_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      cnt_q        <= cnt_d;
      issued_all_q <= issued_all_d;
      rd_vld_q     <= rd_vld_d;
      rd_addr_q    <= rd_addr_d;
      hold_vld_q   <= hold_vld_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      live_addr_q  <= live_addr_d;
      live_data_q  <= live_data_d;
      live_we_q    <= live_we_d;
      cpu_ack_q    <= cpu_ack_d;
      last_wr_q    <= last_wr_d;
    end
  end

  assign busy      = (state_q == COPY);
  assign done      = (state_q == DONE);
  assign overrun   = overrun_q;
  assign sh_addr   = cnt_q;
  assign cpu_ack   = cpu_ack_q;
  assign live_addr = live_addr_q;
  assign live_data = live_data_q;
  assign live_we   = live_we_q;

endmodule

// File: tb/tb_jtcop_pal_sched.sv
// Randomized bench for jtcop_pal_sched: a shadow RAM model plus a scoreboard of the
// expected live-palette write stream, CPU acks, done timing and overrun behaviour.
module tb_jtcop_pal_sched;
  localparam int AW = 10;
  localparam int DW = 24;
  localparam int N  = 1 << AW;

  logic          rst, clk, LVBL, trig, auto_en;
  logic          busy, done, overrun;
  logic [AW-1:0] sh_addr;
  logic [DW-1:0] sh_dout;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic [2:0]    cpu_mask;
  logic          cpu_ack;
  logic [AW-1:0] live_addr;
  logic [DW-1:0] live_data;
  logic [2:0]    live_we;

  jtcop_pal_sched #(.AW(AW), .DW(DW)) dut (
    .rst(rst), .clk(clk), .LVBL(LVBL), .trig(trig), .auto_en(auto_en),
    .busy(busy), .done(done), .overrun(overrun),
    .sh_addr(sh_addr), .sh_dout(sh_dout),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_mask(cpu_mask),
    .cpu_ack(cpu_ack),
    .live_addr(live_addr), .live_data(live_data), .live_we(live_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] shadow [N];
  always @(posedge clk) sh_dout <= shadow[sh_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    mask;
  } cpu_exp_t;

  cpu_exp_t cpu_q[$];
  cpu_exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;
  bit copy_act = 0;
  int start_cyc = 0;
  int next_k = 0;
  int stalls = 0;
  int done_cnt = 0;
  int exp_done = 0;
  bit model_pend = 0;
  bit model_ovr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: copy entries in ascending order, each CPU write shifts the rest by one clk.
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (cpu_ack) begin
        if (cpu_q.size() == 0) begin
          chk("cpu_ack_unexpected", 1, 0);
        end else begin
          mon_e = cpu_q.pop_front();
          chk("cpu_time", cyc, mon_e.cyc);
          chk("cpu_write", {live_addr, live_data, live_we}, {mon_e.addr, mon_e.data, mon_e.mask});
          $display("cpu write  cyc=%0d addr=%0h data=%0h we=%0b", cyc, live_addr, live_data, live_we);
          if (copy_act) stalls++;
        end
      end else if (live_we != 3'b000) begin
        if (!copy_act || next_k >= N) begin
          chk("copy_write_unexpected", {1'b1, live_addr, live_we}, 0);
        end else begin
          chk("copy_write", {live_addr, live_data, live_we}, {AW'(next_k), shadow[next_k], 3'b111});
          chk("copy_time", cyc, start_cyc + next_k + 2 + stalls);
          next_k++;
        end
      end
      if (done) begin
        done_cnt++;
        if (!copy_act) begin
          chk("done_unexpected", 1, 0);
        end else begin
          chk("done_time", cyc, start_cyc + N + 2 + stalls);
          chk("done_entries", next_k, N);
          chk("done_busy", busy, 0);
          $display("copy done  cyc=%0d start=%0d entries=%0d stalls=%0d", cyc, start_cyc, next_k, stalls);
        end
        copy_act = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic fill_shadow(input bit ramp);
    for (int k = 0; k < N; k++) shadow[k] = ramp ? DW'(k * 3) : DW'($urandom);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    model_pend = 1'b1;
    tick(1);
    trig = 1'b0;
  endtask

  task automatic blank(input bit trig_too);
    bit go, was_busy;
    was_busy = copy_act;
    go = !copy_act && (model_pend || auto_en);
    LVBL = 1'b0;
    trig = trig_too;
    if (go) begin
      start_cyc = cyc;
      next_k = 0;
      stalls = 0;
      copy_act = 1;
      exp_done++;
      model_pend = trig_too;
      model_ovr = 1'b0;
    end else if (trig_too) begin
      model_pend = 1'b1;
    end
    tick(1);
    trig = 1'b0;
    $display("blank      cyc=%0d start=%0b busy=%0b", cyc, go, busy);
    chk("busy_after_blank", busy, go || was_busy);
    if (go) chk("overrun_cleared", overrun, 0);
  endtask

  task automatic unblank();
    if (copy_act) model_ovr = 1'b1;
    LVBL = 1'b1;
    tick(2);
    chk("overrun", overrun, model_ovr);
  endtask

  task automatic wait_done(input int exp_stalls);
    int n;
    n = 0;
    while (copy_act && n < 1400) begin
      tick(1);
      n++;
    end
    if (copy_act) begin
      chk("done_timeout", 0, 1);
      copy_act = 0;
    end
    chk("stalls", stalls, exp_stalls);
    tick(3);
    chk("idle_busy", busy, 0);
    chk("done_count", done_cnt, exp_done);
    chk("cpu_all_acked", cpu_q.size(), 0);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] m);
    cpu_exp_t e;
    e.cyc = cyc + 1;
    e.addr = a;
    e.data = d;
    e.mask = m;
    cpu_q.push_back(e);
    cpu_req = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    cpu_mask = m;
    // Request held across the ack cycle: it must not issue a second write.
    tick(2);
    cpu_req = 1'b0;
    cpu_addr = AW'($urandom);
    cpu_data = DW'($urandom);
    cpu_mask = 3'($urandom);
  endtask

  initial begin
    rst = 1'b1; LVBL = 1'b1; trig = 1'b0; auto_en = 1'b0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0; cpu_mask = '0;
    fill_shadow(1);
    tick(3);
    chk("reset_outputs", {busy, done, overrun, cpu_ack, live_we, sh_addr, live_addr, live_data}, 0);
    rst = 1'b0;
    tick(2);

    // Triggered copy of a ramp (k*3)
    pulse_trig();
    tick(3);
    blank(0);
    wait_done(0);
    unblank();

    // CPU writes while idle, including an all-lanes-off mask
    for (int i = 0; i < 4; i++) begin
      cpu_write(AW'($urandom), DW'($urandom), (i == 0) ? 3'b000 : 3'($urandom));
      tick(2);
    end
    chk("idle_cpu_acked", cpu_q.size(), 0);

    // Auto mode: two blanks, two copies; pending must stay clear
    auto_en = 1'b1;
    fill_shadow(0);
    blank(0);
    wait_done(0);
    unblank();
    fill_shadow(0);
    blank(0);
    wait_done(0);
    unblank();
    auto_en = 1'b0;
    blank(0);
    tick(20);
    chk("no_copy_without_pending", busy, 0);
    unblank();

    // CPU writes stalling a copy
    fill_shadow(0);
    pulse_trig();
    blank(0);
    wait_until(start_cyc + 100);
    cpu_write(10'h3FF, 24'h123456, 3'b001);
    wait_until(start_cyc + 300 + int'($urandom_range(0, 100)));
    cpu_write(AW'($urandom), DW'($urandom), 3'b000);
    wait_until(start_cyc + 600 + int'($urandom_range(0, 200)));
    cpu_write(AW'($urandom), DW'($urandom), 3'($urandom));
    wait_done(3);
    unblank();

    // Overrun: blank ends mid-copy, a second fall mid-copy is ignored
    fill_shadow(0);
    pulse_trig();
    blank(0);
    wait_until(start_cyc + 500);
    unblank();
    wait_until(start_cyc + 700);
    blank(0);
    wait_done(0);
    chk("overrun_sticky", overrun, 1);
    unblank();

    // Next start clears overrun; trig while busy waits; trig at start keeps pending
    fill_shadow(0);
    pulse_trig();
    blank(0);
    wait_until(start_cyc + 300);
    pulse_trig();
    wait_done(0);
    tick(5);
    chk("no_restart_mid_copy", busy, 0);
    unblank();
    blank(1);
    wait_done(0);
    unblank();
    blank(0);
    wait_done(0);
    unblank();
    blank(0);
    tick(20);
    chk("pending_consumed", busy, 0);
    unblank();

    // Reset mid-copy
    fill_shadow(0);
    pulse_trig();
    blank(0);
    wait_until(start_cyc + 302);
    rst = 1'b1;
    copy_act = 0;
    exp_done--;
    model_pend = 1'b0;
    model_ovr = 1'b0;
    tick(2);
    chk("reset_mid_copy", {busy, done, overrun, cpu_ack, live_we, sh_addr, live_addr, live_data}, 0);
    rst = 1'b0;
    tick(20);
    chk("no_copy_after_reset", busy, 0);
    unblank();
    pulse_trig();
    blank(0);
    wait_done(0);
    unblank();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
